al_alu_chain_pipe: RTL and testbench

- Parametrised, pipelined successor to the 2-bit carry-chain ALU slice.
- Splits a WIDTH-bit carry chain into SEG-bit segments, with a register between segments. Carry ripples one segment per cycle.
- Adds subtract, an accumulate mode with per-segment feedback, a flags output and a valid/ready handshake.
- Used as the fabric-mapped adder/accumulator for wide datapaths where a single-cycle ripple chain misses timing.

---
 rtl/al_alu_chain_pipe.sv | 108 ++++++++++
 tb/tb_al_alu_chain_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/al_alu_chain_pipe.sv
// Segmented carry-chain ALU: WIDTH bits split into SEG-bit stages with a
// register between segments, plus per-segment accumulator and handshake.
module al_alu_chain_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    typedef struct packed {
        logic             valid;
        logic             acc;
        logic             clr;
        logic             c;
        logic             ovf;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [WIDTH-1:0] res;
    } stage_t;

    stage_t           entry;
    stage_t           stg_in  [STAGES];
    stage_t           nxt     [STAGES];
    stage_t           pipe    [STAGES];
    logic [SEG-1:0]   acc_seg [STAGES];
    logic [SEG-1:0]   x_seg   [STAGES];
    logic [SEG-1:0]   y_seg   [STAGES];
    logic [SEG:0]     sum_ext [STAGES];
    logic [WIDTH-1:0] src_b;
    logic             stall;

    assign stall    = pipe[STAGES-1].valid & ~out_ready;
    assign in_ready = ~stall;

    // Inversion for subtraction is applied once at entry; upper operand
    // bits then ride along the pipe until their segment is reached.
    assign src_b = op[1] ? a : b;

    always_comb begin
        entry       = '0;
        entry.valid = in_valid;
        entry.acc   = op[1];
        entry.clr   = acc_clr;
        entry.c     = op[0] ? 1'b1 : cin;
        entry.opa   = a;
        entry.opb   = op[0] ? ~src_b : src_b;
    end

    assign stg_in[0] = entry;

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign stg_in[k] = pipe[k-1];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]   = stg_in[k];
            x_seg[k] = stg_in[k].acc
                     ? (stg_in[k].clr ? '0 : acc_seg[k])
                     : stg_in[k].opa[k*SEG +: SEG];
            y_seg[k] = stg_in[k].opb[k*SEG +: SEG];
            sum_ext[k] = {1'b0, x_seg[k]} + {1'b0, y_seg[k]}
                       + {{SEG{1'b0}}, stg_in[k].c};
            nxt[k].res[k*SEG +: SEG] = sum_ext[k][SEG-1:0];
            nxt[k].c   = sum_ext[k][SEG];
            nxt[k].ovf = (x_seg[k][SEG-1] == y_seg[k][SEG-1])
                       && (sum_ext[k][SEG-1] != x_seg[k][SEG-1]);
        end
    end

    // Accumulator segment k sees op n+1 exactly one cycle after op n,
    // so it is always current when the next op arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k]    <= '0;
                acc_seg[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= nxt[k];
                if (stg_in[k].valid && stg_in[k].acc)
                    acc_seg[k] <= sum_ext[k][SEG-1:0];
            end
        end
    end

    assign out_valid = pipe[STAGES-1].valid;
    assign sum       = pipe[STAGES-1].res;
    assign cout      = pipe[STAGES-1].c;
    assign ovf       = pipe[STAGES-1].ovf;

endmodule

// File: tb/tb_al_alu_chain_pipe.sv
// Bench for al_alu_chain_pipe: directed table, corner sequences and a
// random stream scored against an arithmetic reference model.
module tb_al_alu_chain_pipe;

    localparam int W = 16;
    localparam int S = 4;
    localparam int LAT = W / S;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic         acc_clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    al_alu_chain_pipe #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_clr(acc_clr), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pop    = 0;

    logic         bp_mode  = 1'b0;
    logic         or_force = 1'b1;
    logic         rnd_or   = 1'b1;
    logic         tab_mode = 1'b1;
    logic [W-1:0] t_s;
    logic         t_c;
    logic         t_v;
    logic [W-1:0] m_acc = '0;
    logic [17:0]  exp_q[$];

    assign out_ready = bp_mode ? rnd_or : or_force;

    always @(posedge clk) begin
        #1 rnd_or = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference: plain integer arithmetic on whole words, in op order.
    function automatic logic [17:0] model(input logic [1:0] o,
                                          input logic clr,
                                          input logic [W-1:0] xa,
                                          input logic [W-1:0] xb,
                                          input logic ci);
        logic [W-1:0] x, y, s;
        logic c, v;
        int sx, sy, r, u;
        x  = o[1] ? (clr ? '0 : m_acc) : xa;
        y  = o[1] ? xa : xb;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (o[0]) begin
            s = x - y;
            c = (x >= y);
            r = sx - sy;
        end else begin
            u = int'(x) + int'(y) + int'(ci);
            s = u[W-1:0];
            c = (u > 65535);
            r = sx + sy + int'(ci);
        end
        v = (r > 32767) || (r < -32768);
        if (o[1]) m_acc = s;
        return {v, c, s};
    endfunction

    always @(negedge clk) begin
        logic [17:0] e;
        logic [17:0] m;
        if (rst) begin
            exp_q.delete();
            m_acc = '0;
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", 32'(sum), 32'(e[15:0]));
                    chk("cout", 32'(cout), 32'(e[16]));
                    chk("ovf", 32'(ovf), 32'(e[17]));
                end
            end
            if (in_valid && in_ready) begin
                m = model(op, acc_clr, a, b, cin);
                exp_q.push_back(tab_mode ? {t_v, t_c, t_s} : m);
            end
        end
    end

    task automatic drive_in(input logic [1:0] o, input logic clr,
                            input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic ci, input logic [W-1:0] es,
                            input logic ec, input logic ev);
        in_valid = 1'b1;
        op = o; acc_clr = clr; a = xa; b = xb; cin = ci;
        t_s = es; t_c = ec; t_v = ev;
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] o, input logic clr,
                        input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic ci, input logic [W-1:0] es,
                        input logic ec, input logic ev);
        drive_in(o, clr, xa, xb, ci, es, ec, ev);
        wait_accept();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [1:0]   op;
        logic         clr;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    vec_t tab[11];

    initial begin #2000000; $display("FAIL watchdog expired"); $fatal; end

    initial begin
        int p0, n;
        tab[0]  = '{2'b00, 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tab[1]  = '{2'b00, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tab[2]  = '{2'b00, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        tab[3]  = '{2'b01, 1'b0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tab[4]  = '{2'b01, 1'b0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        tab[5]  = '{2'b01, 1'b0, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0};
        tab[6]  = '{2'b10, 1'b1, 16'h0FFF, 16'h0000, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        tab[7]  = '{2'b10, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h1000, 1'b0, 1'b0};
        tab[8]  = '{2'b00, 1'b0, 16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0};
        tab[9]  = '{2'b11, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0FFE, 1'b1, 1'b0};
        tab[10] = '{2'b10, 1'b0, 16'h0002, 16'hFFFF, 1'b1, 16'h1001, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; op = '0; acc_clr = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table, back-to-back
        foreach (tab[i])
            send(tab[i].op, tab[i].clr, tab[i].a, tab[i].b, tab[i].cin,
                 tab[i].s, tab[i].c, tab[i].v);
        idle(LAT + 2);
        chk("table_drained", 32'(exp_q.size()), 32'd0);

        // Latency of a single op
        send(2'b00, 1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", 32'(n), 32'(LAT - 1));
        idle(LAT + 2);

        // Backpressure: fill, stall three cycles, release
        for (int i = 1; i <= 4; i++)
            send(2'b00, 1'b0, W'(16'h0100 * i), 16'h0001, 1'b0,
                 W'(16'h0100 * i + 1), 1'b0, 1'b0);
        or_force = 1'b0;
        p0 = n_pop;
        drive_in(2'b00, 1'b0, 16'h0500, 16'h0001, 1'b0, 16'h0501, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_sum_held", 32'(sum), 32'h0101);
            @(posedge clk);
            #1;
        end
        or_force = 1'b1;
        wait_accept();
        idle(LAT + 4);
        chk("drain_count", 32'(n_pop - p0), 32'd5);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        // Reset with ops in flight
        send(2'b10, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b0);
        send(2'b10, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0020, 1'b0, 1'b0);
        send(2'b10, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0030, 1'b0, 1'b0);
        send(2'b10, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0040, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(2'b10, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b0);
        idle(LAT + 3);
        chk("post_rst_empty", 32'(exp_q.size()), 32'd0);
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        // Random stream against the reference model
        tab_mode = 1'b0;
        bp_mode  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                 rnd16(), rnd16(), 1'($urandom_range(0, 1)),
                 '0, 1'b0, 1'b0);
        end
        bp_mode = 1'b0;
        idle(20);
        chk("random_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
